// File: rtl/uart_flow_transceiver.sv
// Full-duplex UART with runtime baud divisor, RTS/CTS flow control and
// first-word-fall-through TX/RX FIFOs. Each RX entry carries its own
// parity/frame error tags.
//
// state    | meaning
// ---------+-------------------------------------------------
// S_IDLE   | line idle, waiting for data (TX) or start edge (RX)
// S_START  | start bit (RX: half-bit glitch re-check)
// S_DATA   | data bits, LSB first
// S_PARITY | parity bit (skipped when parity is disabled)
// S_STOP   | stop bit(s); RX pushes the byte at the mid-sample

`ifndef PARITY_NONE
`define PARITY_NONE 0
`endif
`ifndef PARITY_EVEN
`define PARITY_EVEN 1
`endif
`ifndef PARITY_ODD
`define PARITY_ODD 2
`endif
`ifndef STOP_BITS_ONE
`define STOP_BITS_ONE 1
`endif
`ifndef STOP_BITS_TWO
`define STOP_BITS_TWO 2
`endif

module uart_flow_transceiver #(
  parameter int DATA_WIDTH    = 8,
  parameter int PARITY        = `PARITY_NONE,
  parameter int STOP_BITS     = `STOP_BITS_ONE,
  parameter int OVERSAMPLE    = 16,
  parameter int DIV_WIDTH     = 16,
  parameter int TX_ADDR_WIDTH = 4,
  parameter int RX_ADDR_WIDTH = 4,
  parameter int RTS_MARGIN    = 2
) (
  input  logic                     i_clk,
  input  logic                     i_arst_n,
  input  logic [DIV_WIDTH-1:0]     i_baud_div,
  input  logic                     i_flow_en,
  input  logic                     i_cts_n,
  output logic                     o_rts_n,
  input  logic                     i_rx,
  output logic                     o_tx,
  input  logic                     i_tx_valid,
  input  logic [DATA_WIDTH-1:0]    i_tx_data,
  output logic                     o_tx_ready,
  output logic                     o_rx_valid,
  output logic [DATA_WIDTH-1:0]    o_rx_data,
  output logic                     o_rx_perr,
  output logic                     o_rx_ferr,
  input  logic                     i_rx_ready,
  output logic [TX_ADDR_WIDTH:0]   o_tx_level,
  output logic [RX_ADDR_WIDTH:0]   o_rx_level,
  output logic                     o_overrun,
  input  logic                     i_clr_err,
  output logic                     o_tx_idle
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam int OS_W     = $clog2(OVERSAMPLE);
  localparam int BIT_W    = $clog2(DATA_WIDTH);
  localparam int TX_DEPTH = 2 ** TX_ADDR_WIDTH;
  localparam int RX_DEPTH = 2 ** RX_ADDR_WIDTH;
  localparam int RX_W     = DATA_WIDTH + 2;

  localparam logic [OS_W-1:0]        OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]        OS_HALF   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]        OS_ONE    = OS_W'(1);
  localparam logic [DIV_WIDTH-1:0]   DIV_ONE   = DIV_WIDTH'(1);
  localparam logic [BIT_W-1:0]       BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]       STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [BIT_W-1:0]       BIT_ONE   = BIT_W'(1);
  localparam logic [TX_ADDR_WIDTH:0] TX_FULL   = (TX_ADDR_WIDTH+1)'(TX_DEPTH);
  localparam logic [TX_ADDR_WIDTH:0] TX_LONE   = (TX_ADDR_WIDTH+1)'(1);
  localparam logic [TX_ADDR_WIDTH-1:0] TX_PONE = TX_ADDR_WIDTH'(1);
  localparam logic [RX_ADDR_WIDTH:0] RX_FULL   = (RX_ADDR_WIDTH+1)'(RX_DEPTH);
  localparam logic [RX_ADDR_WIDTH:0] RX_LONE   = (RX_ADDR_WIDTH+1)'(1);
  localparam logic [RX_ADDR_WIDTH-1:0] RX_PONE = RX_ADDR_WIDTH'(1);
  localparam logic [RX_ADDR_WIDTH:0] RTS_LVL   = (RX_ADDR_WIDTH+1)'(RX_DEPTH - RTS_MARGIN);
  localparam logic                   PAR_ODD   = (PARITY == `PARITY_ODD);
  localparam logic                   PAR_ON    = (PARITY != `PARITY_NONE);

  // ---------------- synchronizers ----------------
  logic rx_meta, rx_sync, rx_prev, cts_meta, cts_sync;

  // 2-FF synchronizers for the asynchronous pins, plus one extra RX stage for edge detect
  always_ff @(posedge i_clk) begin
    if (!i_arst_n) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      cts_meta <= 1'b1;
      cts_sync <= 1'b1;
    end else begin
      rx_meta  <= i_rx;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      cts_meta <= i_cts_n;
      cts_sync <= cts_meta;
    end
  end

  // ---------------- TX FIFO ----------------
  logic [DATA_WIDTH-1:0]    tx_mem [TX_DEPTH];
  logic [TX_ADDR_WIDTH-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [TX_ADDR_WIDTH:0]   tx_level;
  logic [DATA_WIDTH-1:0]    tx_head;
  logic                     tx_push, tx_pop, tx_empty, tx_full;

  assign tx_full    = (tx_level == TX_FULL);
  assign tx_empty   = (tx_level == '0);
  assign tx_push    = i_tx_valid & ~tx_full;
  assign tx_head    = tx_mem[tx_rd_ptr];
  assign o_tx_ready = ~tx_full;
  assign o_tx_level = tx_level;

  // TX storage, written on accepted host writes
  always_ff @(posedge i_clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= i_tx_data;
  end

  // TX pointers and occupancy
  always_ff @(posedge i_clk) begin
    if (!i_arst_n) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_level  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_PONE;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_PONE;
      if (tx_push && !tx_pop)      tx_level <= tx_level + TX_LONE;
      else if (!tx_push && tx_pop) tx_level <= tx_level - TX_LONE;
    end
  end

  // ---------------- TX engine ----------------
  logic [2:0]            tx_state;
  logic [DIV_WIDTH-1:0]  tx_div_q, tx_pre;
  logic [OS_W-1:0]       tx_os;
  logic [BIT_W-1:0]      tx_bit;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic                  tx_par;
  logic                  tx_tick, tx_bit_end, tx_start_ok, tx_line;

  assign tx_tick     = (tx_pre == '0);
  assign tx_bit_end  = tx_tick && (tx_os == '0);
  assign tx_start_ok = !tx_empty && (!i_flow_en || !cts_sync);
  // CTS gates only frame starts: from idle, or straight after the last stop bit
  assign tx_pop = tx_start_ok &&
                  ((tx_state == S_IDLE) ||
                   (tx_state == S_STOP && tx_bit_end && tx_bit == STOP_LAST));
  assign o_tx_idle = tx_empty && (tx_state == S_IDLE);

  always_comb begin
    tx_line = 1'b1;
    case (tx_state)
      S_START:  tx_line = 1'b0;
      S_DATA:   tx_line = tx_shift[0];
      S_PARITY: tx_line = tx_par;
      default:  tx_line = 1'b1;
    endcase
  end

  // TX frame sequencer; a pop reloads the prescaler and the shift register
  always_ff @(posedge i_clk) begin
    if (!i_arst_n) begin
      tx_state <= S_IDLE;
      tx_div_q <= '0;
      tx_pre   <= '0;
      tx_os    <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      o_tx     <= 1'b1;
    end else begin
      o_tx <= tx_line;
      if (tx_state != S_IDLE) begin
        tx_pre <= tx_tick ? tx_div_q : tx_pre - DIV_ONE;
        if (tx_tick) tx_os <= (tx_os == '0) ? OS_LAST : tx_os - OS_ONE;
      end
      case (tx_state)
        S_START: if (tx_bit_end) begin
          tx_state <= S_DATA;
          tx_bit   <= '0;
        end
        S_DATA: if (tx_bit_end) begin
          tx_shift <= tx_shift >> 1;
          if (tx_bit == BIT_LAST) begin
            tx_state <= PAR_ON ? S_PARITY : S_STOP;
            tx_bit   <= '0;
          end else begin
            tx_bit <= tx_bit + BIT_ONE;
          end
        end
        S_PARITY: if (tx_bit_end) begin
          tx_state <= S_STOP;
          tx_bit   <= '0;
        end
        S_STOP: if (tx_bit_end) begin
          if (tx_bit == STOP_LAST) tx_state <= S_IDLE;
          else                     tx_bit   <= tx_bit + BIT_ONE;
        end
        default: tx_state <= S_IDLE;
      endcase
      if (tx_pop) begin
        tx_state <= S_START;
        tx_div_q <= i_baud_div;
        tx_pre   <= i_baud_div;
        tx_os    <= OS_LAST;
        tx_bit   <= '0;
        tx_shift <= tx_head;
        tx_par   <= (^tx_head) ^ PAR_ODD;
      end
    end
  end

  // ---------------- RX engine ----------------
  logic [2:0]            rx_state;
  logic [DIV_WIDTH-1:0]  rx_div_q, rx_pre;
  logic [OS_W-1:0]       rx_os;
  logic [BIT_W-1:0]      rx_bit;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic                  rx_par_q;
  logic                  rx_tick, rx_sample, rx_push, rx_perr;
  logic [RX_W-1:0]       rx_word;

  assign rx_tick   = (rx_pre == '0);
  assign rx_sample = rx_tick && (rx_os == '0);
  assign rx_push   = (rx_state == S_STOP) && rx_sample;
  assign rx_perr   = PAR_ON && (((^rx_shift) ^ PAR_ODD) != rx_par_q);
  assign rx_word   = {~rx_sync, rx_perr, rx_shift};

  // RX frame sequencer; first sample point is half a bit after the start edge
  always_ff @(posedge i_clk) begin
    if (!i_arst_n) begin
      rx_state <= S_IDLE;
      rx_div_q <= '0;
      rx_pre   <= '0;
      rx_os    <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_par_q <= 1'b0;
    end else begin
      if (rx_state != S_IDLE) begin
        rx_pre <= rx_tick ? rx_div_q : rx_pre - DIV_ONE;
        if (rx_tick) rx_os <= (rx_os == '0) ? OS_LAST : rx_os - OS_ONE;
      end
      case (rx_state)
        S_IDLE: if (rx_prev && !rx_sync) begin
          rx_state <= S_START;
          rx_div_q <= i_baud_div;
          rx_pre   <= i_baud_div;
          rx_os    <= OS_HALF;
        end
        S_START: if (rx_sample) begin
          rx_state <= rx_sync ? S_IDLE : S_DATA;
          rx_bit   <= '0;
        end
        S_DATA: if (rx_sample) begin
          rx_shift <= {rx_sync, rx_shift[DATA_WIDTH-1:1]};
          if (rx_bit == BIT_LAST) begin
            rx_state <= PAR_ON ? S_PARITY : S_STOP;
            rx_bit   <= '0;
          end else begin
            rx_bit <= rx_bit + BIT_ONE;
          end
        end
        S_PARITY: if (rx_sample) begin
          rx_par_q <= rx_sync;
          rx_state <= S_STOP;
        end
        S_STOP: if (rx_sample) rx_state <= S_IDLE;
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [RX_W-1:0]          rx_mem [RX_DEPTH];
  logic [RX_ADDR_WIDTH-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [RX_ADDR_WIDTH:0]   rx_level;
  logic [RX_W-1:0]          rx_head;
  logic                     rx_full, rx_wr, rx_rd;

  assign rx_full    = (rx_level == RX_FULL);
  assign rx_wr      = rx_push & ~rx_full;
  assign rx_rd      = o_rx_valid & i_rx_ready;
  assign rx_head    = rx_mem[rx_rd_ptr];
  assign o_rx_valid = (rx_level != '0);
  assign o_rx_data  = rx_head[DATA_WIDTH-1:0];
  assign o_rx_perr  = rx_head[DATA_WIDTH];
  assign o_rx_ferr  = rx_head[DATA_WIDTH+1];
  assign o_rx_level = rx_level;

  // RX storage, written when a completed byte finds room
  always_ff @(posedge i_clk) begin
    if (rx_wr) rx_mem[rx_wr_ptr] <= rx_word;
  end

  // RX pointers, occupancy, sticky overrun and registered RTS
  always_ff @(posedge i_clk) begin
    if (!i_arst_n) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_level  <= '0;
      o_overrun <= 1'b0;
      o_rts_n   <= 1'b1;
    end else begin
      if (rx_wr) rx_wr_ptr <= rx_wr_ptr + RX_PONE;
      if (rx_rd) rx_rd_ptr <= rx_rd_ptr + RX_PONE;
      if (rx_wr && !rx_rd)      rx_level <= rx_level + RX_LONE;
      else if (!rx_wr && rx_rd) rx_level <= rx_level - RX_LONE;
      if (rx_push && rx_full) o_overrun <= 1'b1;
      else if (i_clr_err)     o_overrun <= 1'b0;
      o_rts_n <= i_flow_en && (rx_level >= RTS_LVL);
    end
  end

endmodule

// File: tb/tb_uart_flow_transceiver.sv
// Directed bench for uart_flow_transceiver: 8E1, div=3, 16x oversampling
// (64 clocks per bit, 704 clocks per frame).

`ifndef PARITY_NONE
`define PARITY_NONE 0
`endif
`ifndef PARITY_EVEN
`define PARITY_EVEN 1
`endif
`ifndef PARITY_ODD
`define PARITY_ODD 2
`endif
`ifndef STOP_BITS_ONE
`define STOP_BITS_ONE 1
`endif
`ifndef STOP_BITS_TWO
`define STOP_BITS_TWO 2
`endif

module tb_uart_flow_transceiver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] baud_div;
  logic        flow_en, cts_n, rts_n, rx, tx;
  logic        tx_valid, tx_ready, rx_valid, rx_perr, rx_ferr, rx_ready;
  logic [7:0]  tx_data, rx_data;
  logic [4:0]  tx_level, rx_level;
  logic        overrun, clr_err, tx_idle;
  logic        loop_en, rx_drv;
  int          vectors = 0;
  int          errors = 0;
  int          cyc = 0;
  int          t0, t1, n;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rx = loop_en ? tx : rx_drv;

  uart_flow_transceiver #(
    .DATA_WIDTH(8), .PARITY(`PARITY_EVEN), .STOP_BITS(`STOP_BITS_ONE),
    .OVERSAMPLE(16), .DIV_WIDTH(16), .TX_ADDR_WIDTH(4), .RX_ADDR_WIDTH(4),
    .RTS_MARGIN(2)
  ) dut (
    .i_clk(clk), .i_arst_n(rst_n), .i_baud_div(baud_div),
    .i_flow_en(flow_en), .i_cts_n(cts_n), .o_rts_n(rts_n),
    .i_rx(rx), .o_tx(tx),
    .i_tx_valid(tx_valid), .i_tx_data(tx_data), .o_tx_ready(tx_ready),
    .o_rx_valid(rx_valid), .o_rx_data(rx_data), .o_rx_perr(rx_perr),
    .o_rx_ferr(rx_ferr), .i_rx_ready(rx_ready),
    .o_tx_level(tx_level), .o_rx_level(rx_level),
    .o_overrun(overrun), .i_clr_err(clr_err), .o_tx_idle(tx_idle)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic put_tx(input logic [7:0] d);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic pop_rx();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [7:0] d, input logic pe, input logic fe);
    check({tag, "_valid"}, rx_valid, 1);
    check({tag, "_data"}, rx_data, d);
    check({tag, "_perr"}, rx_perr, pe);
    check({tag, "_ferr"}, rx_ferr, fe);
  endtask

  task automatic send_rx(input logic [7:0] d, input logic par, input logic stp);
    logic [10:0] f;
    f = {stp, par, d, 1'b0};
    for (int j = 0; j < 11; j++) begin
      rx_drv = f[j];
      step(64);
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    logic [10:0] frame1;
    rst_n = 1'b0; baud_div = 16'd3; flow_en = 1'b0; cts_n = 1'b0;
    tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0; clr_err = 1'b0;
    loop_en = 1'b0; rx_drv = 1'b1;
    step(3);
    check("rst_tx", tx, 1);
    check("rst_rts", rts_n, 1);
    check("rst_overrun", overrun, 0);
    check("rst_tx_idle", tx_idle, 1);
    check("rst_tx_level", tx_level, 0);
    check("rst_rx_level", rx_level, 0);
    check("rst_rx_valid", rx_valid, 0);
    rst_n = 1'b1;
    step(2);
    check("flow_off_rts", rts_n, 0);

    // 1: single 0xA5 frame waveform, even parity bit = 0
    frame1 = {1'b1, 1'b0, 8'hA5, 1'b0};
    put_tx(8'hA5);
    check("t1_level_after_write", tx_level, 1);
    check("t1_line_before_start", tx, 1);
    step(1);
    check("t1_popped", tx_level, 0);
    check("t1_line_one_clk", tx, 1);
    step(1);
    for (int i = 0; i < 704; i++) begin
      check($sformatf("t1_wave_%0d", i), tx, frame1[i/64]);
      if (i == 300) check("t1_busy", tx_idle, 0);
      step(1);
    end
    check("t1_idle_after", tx_idle, 1);
    check("t1_line_after", tx, 1);

    // 2: loopback burst 0x00..0x0F, frames back-to-back
    loop_en = 1'b1;
    step(4);
    put_tx(8'h00);
    t0 = cyc;
    for (int i = 1; i < 16; i++) put_tx(8'(i));
    n = 0;
    while (!tx_idle && n < 13000) begin step(1); n++; end
    t1 = cyc;
    check("t2_idle_reached", tx_idle, 1);
    check("t2_no_gap_span", t1 - t0, 11265);
    step(4);
    check("t2_rx_level", rx_level, 16);
    check("t2_no_overrun", overrun, 0);
    for (int i = 0; i < 16; i++) begin
      check_head($sformatf("t2_byte%0d", i), 8'(i), 1'b0, 1'b0);
      pop_rx();
    end
    check("t2_drained", rx_level, 0);
    loop_en = 1'b0;
    step(4);

    // 3: parity-corrupted 0x3C, then 0x00 with a low stop bit
    send_rx(8'h3C, 1'b1, 1'b1);
    send_rx(8'h00, 1'b0, 1'b0);
    step(64);
    check("t3_level", rx_level, 2);
    check_head("t3_perr_byte", 8'h3C, 1'b1, 1'b0);
    pop_rx();
    check_head("t3_ferr_byte", 8'h00, 1'b0, 1'b1);
    pop_rx();
    check("t3_drained", rx_level, 0);

    // 4: fill RX without popping, overrun and RTS threshold
    flow_en = 1'b1;
    step(2);
    check("t4_rts_empty", rts_n, 0);
    for (int k = 1; k <= 17; k++) begin
      send_rx(8'(8'h40 + k), ^(8'(8'h40 + k)), 1'b1);
      step(2);
      check($sformatf("t4_level_%0d", k), rx_level, (k > 16) ? 16 : k);
      check($sformatf("t4_rts_%0d", k), rts_n, (k >= 14) ? 1 : 0);
      check($sformatf("t4_overrun_%0d", k), overrun, (k == 17) ? 1 : 0);
    end
    step(10);
    check("t4_overrun_sticky", overrun, 1);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    check("t4_overrun_cleared", overrun, 0);
    for (int k = 1; k <= 16; k++) begin
      check_head($sformatf("t4_byte%0d", k), 8'(8'h40 + k), 1'b0, 1'b0);
      pop_rx();
    end
    check("t4_17th_absent", rx_valid, 0);
    step(2);
    check("t4_rts_drained", rts_n, 0);

    // 5: CTS gating at frame start only
    loop_en = 1'b1;
    cts_n = 1'b1;
    step(4);
    put_tx(8'h81);
    put_tx(8'h42);
    put_tx(8'hE7);
    step(100);
    check("t5_held_line", tx, 1);
    check("t5_held_level", tx_level, 3);
    cts_n = 1'b0;
    n = 0;
    while (tx_level != 5'd1 && n < 2000) begin step(1); n++; end
    check("t5_frame2_started", tx_level, 1);
    step(300);
    cts_n = 1'b1;
    step(800);
    check("t5_frame3_held_level", tx_level, 1);
    check("t5_frame3_held_line", tx, 1);
    check("t5_not_idle", tx_idle, 0);
    check("t5_rx_two", rx_level, 2);
    cts_n = 1'b0;
    n = 0;
    while (!tx_idle && n < 2000) begin step(1); n++; end
    check("t5_frame3_sent", tx_idle, 1);
    step(50);
    check("t5_rx_three", rx_level, 3);
    check_head("t5_b0", 8'h81, 1'b0, 1'b0); pop_rx();
    check_head("t5_b1", 8'h42, 1'b0, 1'b0); pop_rx();
    check_head("t5_b2", 8'hE7, 1'b0, 1'b0); pop_rx();
    loop_en = 1'b0;

    // 6: start-bit glitch, TX full, reset mid-frame
    step(4);
    rx_drv = 1'b0;
    step(8);
    rx_drv = 1'b1;
    step(200);
    check("t6_glitch_level", rx_level, 0);
    check("t6_glitch_valid", rx_valid, 0);
    cts_n = 1'b1;
    for (int i = 0; i < 17; i++) put_tx(8'(8'hC0 + i));
    check("t6_full_level", tx_level, 16);
    check("t6_full_ready", tx_ready, 0);
    cts_n = 1'b0;
    n = 0;
    while (tx !== 1'b0 && n < 100) begin step(1); n++; end
    check("t6_frame_started", tx, 0);
    step(10);
    rst_n = 1'b0;
    step(1);
    check("t6_rst_line", tx, 1);
    check("t6_rst_tx_level", tx_level, 0);
    check("t6_rst_rx_level", rx_level, 0);
    check("t6_rst_idle", tx_idle, 1);
    check("t6_rst_rts", rts_n, 1);
    rst_n = 1'b1;
    flow_en = 1'b0;
    step(50);
    check("t6_post_line", tx, 1);
    check("t6_post_idle", tx_idle, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
